// File: rtl/tx_redundant_framer.sv
// Ethernet test-frame generator: sends every segment `redundancy` times,
// each frame tagged with copy index and segment number, CRC-32 FCS appended.
module tx_redundant_framer #(
    parameter int          PAYLOAD_LEN = 46,
    parameter int          IFG_CYCLES  = 12,
    parameter logic [47:0] DST_MAC     = 48'hFFFFFFFFFFFF,
    parameter logic [47:0] SRC_MAC     = 48'h000A35000102,
    parameter logic [15:0] ETHERTYPE   = 16'h88B5
) (
    input  logic        clk125MHz,
    input  logic        rstn,
    input  logic        start,
    input  logic [7:0]  redundancy,
    input  logic [7:0]  segment_number_max,
    output logic [7:0]  tx_data,
    output logic        tx_en,
    output logic        busy,
    output logic        done,
    output logic [31:0] frame_count
);

    typedef enum logic [2:0] {
        IDLE, PREAMBLE, HEADER, PAYLOAD, FCS, IFG, DONE
    } state_t;

    localparam logic [15:0] PAY_LAST = 16'(PAYLOAD_LEN - 1);
    localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 1);

    state_t      state_reg, state_next;
    logic [15:0] cnt_reg, cnt_next;
    logic [7:0]  red_reg, smax_reg, copy_reg;
    logic [15:0] seg_reg;
    logic [31:0] crc_reg, crc_next;
    logic [31:0] frame_count_reg;
    logic [31:0] fcs_inv;
    logic [135:0] hdr_vec;
    logic [7:0]  hdr_bytes [0:31];
    logic [7:0]  fcs_bytes [0:3];
    logic        last_frame;

    // Byte-wise reflected CRC-32 step (poly EDB88320), LSB of the byte first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc_in ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    // Header fields in wire order; the last three bytes are copy and seg.
    assign hdr_vec = {DST_MAC, SRC_MAC, ETHERTYPE, copy_reg, seg_reg};
    assign fcs_inv = ~crc_reg;

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_hdr
            if (gi < 17) begin : g_used
                assign hdr_bytes[gi] = hdr_vec[135 - 8*gi -: 8];
            end else begin : g_pad
                assign hdr_bytes[gi] = 8'h00;
            end
        end
        for (genvar gi = 0; gi < 4; gi++) begin : g_fcs
            assign fcs_bytes[gi] = fcs_inv[8*gi +: 8];
        end
    endgenerate

    assign last_frame = (seg_reg == ({8'd0, smax_reg} - 16'd1)) &&
                        (copy_reg == (red_reg - 8'd1));

    assign busy        = (state_reg != IDLE);
    assign done        = (state_reg == DONE);
    assign frame_count = frame_count_reg;

    // Next-state, byte mux and combinational CRC update for the current byte.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + 16'd1;
        tx_en      = 1'b0;
        tx_data    = 8'h00;
        crc_next   = crc_reg;
        case (state_reg)
            IDLE: begin
                if (start) state_next = PREAMBLE;
            end
            PREAMBLE: begin
                tx_en    = 1'b1;
                tx_data  = (cnt_reg == 16'd7) ? 8'hD5 : 8'h55;
                crc_next = 32'hFFFFFFFF;
                if (cnt_reg == 16'd7) state_next = HEADER;
            end
            HEADER: begin
                tx_en    = 1'b1;
                tx_data  = hdr_bytes[cnt_reg[4:0]];
                crc_next = crc32_byte(crc_reg, tx_data);
                if (cnt_reg == 16'd16) state_next = PAYLOAD;
            end
            PAYLOAD: begin
                tx_en    = 1'b1;
                tx_data  = seg_reg[7:0] + cnt_reg[7:0];
                crc_next = crc32_byte(crc_reg, tx_data);
                if (cnt_reg == PAY_LAST) state_next = FCS;
            end
            FCS: begin
                tx_en   = 1'b1;
                tx_data = fcs_bytes[cnt_reg[1:0]];
                if (cnt_reg == 16'd3) state_next = IFG;
            end
            IFG: begin
                if (cnt_reg == IFG_LAST) state_next = last_frame ? DONE : PREAMBLE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (state_next != state_reg) cnt_next = 16'd0;
    end

    // State, counters, burst parameters, CRC and frame counter.
    always_ff @(posedge clk125MHz) begin
        if (!rstn) begin
            state_reg       <= IDLE;
            cnt_reg         <= 16'd0;
            red_reg         <= 8'd0;
            smax_reg        <= 8'd0;
            copy_reg        <= 8'd0;
            seg_reg         <= 16'd0;
            crc_reg         <= 32'd0;
            frame_count_reg <= 32'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            crc_reg   <= crc_next;
            if (state_reg == IDLE && start) begin
                red_reg  <= (redundancy == 8'd0) ? 8'd1 : redundancy;
                smax_reg <= (segment_number_max == 8'd0) ? 8'd1 : segment_number_max;
                copy_reg <= 8'd0;
                seg_reg  <= 16'd0;
            end
            if (state_reg == FCS && cnt_reg == 16'd3) begin
                frame_count_reg <= frame_count_reg + 32'd1;
            end
            if (state_reg == IFG && cnt_reg == IFG_LAST && !last_frame) begin
                if (copy_reg == red_reg - 8'd1) begin
                    copy_reg <= 8'd0;
                    seg_reg  <= seg_reg + 16'd1;
                end else begin
                    copy_reg <= copy_reg + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tx_redundant_framer.sv
// Directed bench for tx_redundant_framer: table of bursts plus reset corner case.
module tb_tx_redundant_framer;

    localparam int PL  = 46;
    localparam int IFG = 12;
    localparam int FL  = 8 + 17 + PL + 4;
    localparam int PER = FL + IFG;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [7:0]  redundancy;
    logic [7:0]  segment_number_max;
    logic [7:0]  tx_data;
    logic        tx_en;
    logic        busy;
    logic        done;
    logic [31:0] frame_count;

    tx_redundant_framer dut (
        .clk125MHz          (clk),
        .rstn               (rstn),
        .start              (start),
        .redundancy         (redundancy),
        .segment_number_max (segment_number_max),
        .tx_data            (tx_data),
        .tx_en              (tx_en),
        .busy               (busy),
        .done               (done),
        .frame_count        (frame_count)
    );

    always #4 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Capture of transmitted frames and done pulses.
    logic [7:0] byte_q[$];
    int         flen_q[$];
    int         fstart_q[$];
    int         done_q[$];
    int         cur_len = 0;
    bit         in_frame = 0;

    initial forever begin
        @(negedge clk);
        if (tx_en === 1'b1) begin
            if (!in_frame) begin
                fstart_q.push_back(cyc);
                cur_len  = 0;
                in_frame = 1;
            end
            byte_q.push_back(tx_data);
            cur_len++;
        end else if (in_frame) begin
            flen_q.push_back(cur_len);
            in_frame = 0;
        end
        if (done === 1'b1) done_q.push_back(cyc);
    end

    int n_vec = 0;
    int n_bad = 0;
    int exp_fc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in ^ {24'd0, d};
        for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    // Expected non-FCS byte k of a frame with given copy/seg.
    function automatic logic [7:0] model_byte(input int k, input int cp, input int sg);
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] et;
        logic [7:0]  b;
        dst = 48'hFFFFFFFFFFFF;
        src = 48'h000A35000102;
        et  = 16'h88B5;
        if (k < 7)       b = 8'h55;
        else if (k == 7) b = 8'hD5;
        else if (k < 14) b = dst[8*(13-k) +: 8];
        else if (k < 20) b = src[8*(19-k) +: 8];
        else if (k < 22) b = et[8*(21-k) +: 8];
        else if (k == 22) b = 8'(cp);
        else if (k == 23) b = 8'(sg >> 8);
        else if (k == 24) b = 8'(sg);
        else             b = 8'(sg + k - 25);
        return b;
    endfunction

    task automatic clear_capture();
        byte_q.delete();
        flen_q.delete();
        fstart_q.delete();
        done_q.delete();
    endtask

    task automatic pulse_start(input logic [7:0] r, input logic [7:0] m, output int s);
        @(negedge clk);
        redundancy         = r;
        segment_number_max = m;
        start              = 1'b1;
        s                  = cyc;
        @(negedge clk);
        start = 1'b0;
        // Burst parameters are latched; later changes must have no effect.
        redundancy         = 8'h07;
        segment_number_max = 8'h05;
        check("busy_after_start", {63'd0, busy}, 64'd1);
    endtask

    // Compare one captured frame against the model and the CRC residue.
    task automatic check_frame(input int idx, input int off, input int cp, input int sg,
                               input bit flip_test);
        logic [31:0] crc;
        logic [31:0] res;
        logic [7:0]  e;
        int          bad_k;
        logic [7:0]  bad_got;
        logic [7:0]  bad_exp;
        bad_k = -1;
        bad_got = 8'h00;
        bad_exp = 8'h00;
        crc = 32'hFFFFFFFF;
        for (int k = 0; k < FL; k++) begin
            if (k < FL - 4) begin
                e = model_byte(k, cp, sg);
                if (k >= 8) crc = crc_upd(crc, e);
            end else begin
                e = 8'((~crc) >> (8 * (k - (FL - 4))));
            end
            if (bad_k < 0 && byte_q[off + k] !== e) begin
                bad_k   = k;
                bad_got = byte_q[off + k];
                bad_exp = e;
            end
        end
        n_vec++;
        if (bad_k >= 0) begin
            n_bad++;
            $display("FAIL frame%0d_bytes: byte %0d got %02h expected %02h", idx, bad_k, bad_got, bad_exp);
        end
        res = 32'hFFFFFFFF;
        for (int k = 8; k < FL; k++) res = crc_upd(res, byte_q[off + k]);
        check($sformatf("frame%0d_residue", idx), {32'd0, res}, 64'hDEBB20E3);
        if (flip_test) begin
            res = 32'hFFFFFFFF;
            for (int k = 8; k < FL; k++)
                res = crc_upd(res, (k == 30) ? (byte_q[off + k] ^ 8'h10) : byte_q[off + k]);
            check("residue_flip_detected", {63'd0, res == 32'hDEBB20E3}, 64'd0);
        end
    endtask

    // One full burst: start, optional stray starts, wait for done, check all frames.
    task automatic run_vector(input logic [7:0] r, input logic [7:0] m, input bit extra,
                              input int n, input int reff, input bit flip_test);
        int s;
        bit got;
        int off;
        clear_capture();
        pulse_start(r, m, s);
        if (extra) begin
            repeat (100) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        got = 0;
        for (int i = 0; i < 4000; i++) begin
            if (done === 1'b1) begin
                got = 1;
                if (extra) begin
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                end
                break;
            end
            @(negedge clk);
        end
        check("done_seen", {63'd0, got}, 64'd1);
        repeat (200) @(negedge clk);
        exp_fc += n;
        check("done_pulses", 64'(done_q.size()), 64'd1);
        if (done_q.size() > 0) check("done_cycle", 64'(done_q[0]), 64'(s + 1 + n * PER));
        check("frame_total", 64'(flen_q.size()), 64'(n));
        check("frame_count", {32'd0, frame_count}, 64'(exp_fc));
        check("busy_idle", {63'd0, busy}, 64'd0);
        check("tx_en_idle", {63'd0, tx_en}, 64'd0);
        off = 0;
        for (int i = 0; i < n && i < flen_q.size(); i++) begin
            check($sformatf("frame%0d_start", i), 64'(fstart_q[i]), 64'(s + 1 + i * PER));
            check($sformatf("frame%0d_len", i), 64'(flen_q[i]), 64'(FL));
            if (flen_q[i] == FL && off + FL <= byte_q.size())
                check_frame(i, off, i % reff, i / reff, flip_test && i == 0);
            off += flen_q[i];
        end
    endtask

    typedef struct {
        logic [7:0] red;
        logic [7:0] smax;
        bit         extra;
        int         frames;
        int         reff;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int s;
        int target;
        vecs[0] = '{red: 8'd1, smax: 8'd1, extra: 1'b0, frames: 1, reff: 1};
        vecs[1] = '{red: 8'd3, smax: 8'd2, extra: 1'b1, frames: 6, reff: 3};
        vecs[2] = '{red: 8'd0, smax: 8'd0, extra: 1'b0, frames: 1, reff: 1};
        vecs[3] = '{red: 8'd1, smax: 8'd3, extra: 1'b0, frames: 3, reff: 1};

        rstn = 1'b0;
        start = 1'b0;
        redundancy = 8'd0;
        segment_number_max = 8'd0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("rst_tx_en", {63'd0, tx_en}, 64'd0);
        check("rst_tx_data", {56'd0, tx_data}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_frame_count", {32'd0, frame_count}, 64'd0);

        for (int v = 0; v < 4; v++) begin
            run_vector(vecs[v].red, vecs[v].smax, vecs[v].extra, vecs[v].frames,
                       vecs[v].reff, v == 0);
            $display("vector %0d: red=%0d smax=%0d frames=%0d frame_count=%0d",
                     v, vecs[v].red, vecs[v].smax, flen_q.size(), frame_count);
        end

        // Reset during payload byte 10 of the second frame.
        clear_capture();
        pulse_start(8'd2, 8'd1, s);
        target = s + 1 + PER + 35;
        for (int i = 0; i < 1000 && cyc < target; i++) @(negedge clk);
        check("pre_reset_byte", {56'd0, tx_data}, 64'h0A);
        check("pre_reset_frame_count", {32'd0, frame_count}, 64'(exp_fc + 1));
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        exp_fc = 0;
        check("post_reset_tx_en", {63'd0, tx_en}, 64'd0);
        check("post_reset_busy", {63'd0, busy}, 64'd0);
        check("post_reset_frame_count", {32'd0, frame_count}, 64'd0);
        repeat (20) @(negedge clk);
        check("reset_frame_total", 64'(flen_q.size()), 64'd2);
        if (flen_q.size() > 1) check("partial_frame_len", 64'(flen_q[1]), 64'd36);
        $display("reset mid-frame: frames captured=%0d", flen_q.size());

        // Fresh burst after reset starts from seg=0, copy=0.
        run_vector(8'd1, 8'd1, 1'b0, 1, 1, 1'b0);
        $display("restart: frames=%0d frame_count=%0d", flen_q.size(), frame_count);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
